// File: rtl/lsu_rv32i.sv
// lsu_rv32i: RV32I load/store unit placed directly in front of data_mem_rv32i.
// Accepts one request per valid/ready handshake, drives the data memory port,
// returns extended load data with a one-cycle response pulse, and rejects
// illegal, misaligned or out-of-range accesses.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN -- when defined, misaligned
// in-range H/W accesses are split into byte operations instead of erroring.
`timescale 1ns/1ps
module lsu_rv32i #(
    parameter int DMEM_RD_LAT     = 1,
    parameter int DMEM_SIZE_BYTES = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        cu_store,
    output logic [1:0]  cu_storetype,
    output logic [31:0] dmem_addr,
    output logic [31:0] rs2,
    input  logic [31:0] dmem_out
);
    localparam logic [1:0]  RD_LAT  = 2'(DMEM_RD_LAT);
    localparam logic [32:0] SIZE_33 = 33'(DMEM_SIZE_BYTES);

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, ST = 3'd1, LD_WAIT = 3'd2, RESP = 3'd3, ERR = 3'd4,
        SPLIT_ST = 3'd5, SPLIT_LD = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, ST = 3'd1, LD_WAIT = 3'd2, RESP = 3'd3, ERR = 3'd4
    } state_t;
`endif

    state_t      state_r;
    logic [2:0]  funct3_r;
    logic [1:0]  wait_cnt_r;
    logic        illegal_s;
    logic        misalign_s;
    logic        range_err_s;
    logic [2:0]  nbytes_s;
    logic [32:0] last_byte_s;
    logic [31:0] lane_word_s;

    // Sign/zero extension of a right-aligned value according to funct3.
    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
        case (f3)
            3'b000:  extend = {{24{v[7]}}, v[7:0]};
            3'b001:  extend = {{16{v[15]}}, v[15:0]};
            3'b100:  extend = {24'd0, v[7:0]};
            3'b101:  extend = {16'd0, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    // Memory store type encoding derived from funct3 (SW=00, SH=01, SB=10).
    function automatic logic [1:0] store_type(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   store_type = 2'b10;
            2'b01:   store_type = 2'b01;
            default: store_type = 2'b00;
        endcase
    endfunction

    assign req_ready = (state_r == IDLE) & ~reset;

    // Classify the incoming request: size, legality, alignment and range.
    always_comb begin
        illegal_s  = 1'b0;
        misalign_s = 1'b0;
        nbytes_s   = 3'd1;
        case (req_funct3)
            3'b000, 3'b100: begin
                nbytes_s = 3'd1;
            end
            3'b001, 3'b101: begin
                nbytes_s   = 3'd2;
                misalign_s = req_addr[0];
            end
            3'b010: begin
                nbytes_s   = 3'd4;
                misalign_s = |req_addr[1:0];
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
        if (req_we && req_funct3[2]) begin
            illegal_s = 1'b1;
        end else begin
            illegal_s = illegal_s;
        end
        // 33-bit sum so a wrap past 2^32 still reads as out of range
        last_byte_s = {1'b0, req_addr} + {30'd0, nbytes_s} - 33'd1;
        range_err_s = (last_byte_s >= SIZE_33);
        lane_word_s = dmem_out >> {dmem_addr[1:0], 3'b000};
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [1:0]  byte_cnt_r;
    logic [31:0] wdata_r;
    logic [31:0] asm_r;
    logic [1:0]  last_idx_s;
    logic [1:0]  next_cnt_s;
    logic [31:0] asm_s;

    // Byte counter limits and little-endian assembly of split load bytes.
    always_comb begin
        last_idx_s = funct3_r[1] ? 2'd3 : 2'd1;
        next_cnt_s = byte_cnt_r + 2'd1;
        asm_s      = asm_r | ({24'd0, lane_word_s[7:0]} << {byte_cnt_r, 3'b000});
    end
`endif

    // Main controller: state sequencing plus all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            funct3_r     <= 3'd0;
            wait_cnt_r   <= 2'd0;
            cu_store     <= 1'b0;
            cu_storetype <= 2'b00;
            dmem_addr    <= 32'd0;
            rs2          <= 32'd0;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'd0;
            resp_err     <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            byte_cnt_r   <= 2'd0;
            wdata_r      <= 32'd0;
            asm_r        <= 32'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        funct3_r   <= req_funct3;
                        wait_cnt_r <= 2'd0;
                        if (illegal_s || range_err_s) begin
                            state_r    <= ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (misalign_s) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                            dmem_addr  <= req_addr;
                            byte_cnt_r <= 2'd0;
                            asm_r      <= 32'd0;
                            wdata_r    <= req_wdata;
                            if (req_we) begin
                                state_r      <= SPLIT_ST;
                                cu_store     <= 1'b1;
                                cu_storetype <= 2'b10;
                                rs2          <= req_wdata;
                            end else begin
                                state_r <= SPLIT_LD;
                            end
`else
                            state_r    <= ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
`endif
                        end else if (req_we) begin
                            state_r      <= ST;
                            cu_store     <= 1'b1;
                            cu_storetype <= store_type(req_funct3);
                            dmem_addr    <= req_addr;
                            rs2          <= req_wdata;
                        end else begin
                            state_r   <= LD_WAIT;
                            dmem_addr <= req_addr;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ST: begin
                    cu_store   <= 1'b0;
                    state_r    <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                LD_WAIT: begin
                    if (wait_cnt_r == RD_LAT) begin
                        state_r    <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= extend(funct3_r, lane_word_s);
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 2'd1;
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                SPLIT_ST: begin
                    if (byte_cnt_r == last_idx_s) begin
                        cu_store   <= 1'b0;
                        state_r    <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'd0;
                    end else begin
                        byte_cnt_r <= next_cnt_s;
                        dmem_addr  <= dmem_addr + 32'd1;
                        rs2        <= wdata_r >> {next_cnt_s, 3'b000};
                    end
                end
                SPLIT_LD: begin
                    if (wait_cnt_r == RD_LAT) begin
                        asm_r      <= asm_s;
                        wait_cnt_r <= 2'd0;
                        if (byte_cnt_r == last_idx_s) begin
                            state_r    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= extend(funct3_r, asm_s);
                        end else begin
                            byte_cnt_r <= next_cnt_s;
                            dmem_addr  <= dmem_addr + 32'd1;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 2'd1;
                    end
                end
`endif
                RESP, ERR: begin
                    state_r    <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                default: begin
                    state_r    <= IDLE;
                    cu_store   <= 1'b0;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_rv32i.sv
// tb_lsu_rv32i: self-checking bench for lsu_rv32i with a behavioural data
// memory, a table of directed vectors, back-to-back and reset corner cases,
// and randomized requests checked against a reference model.
`timescale 1ns/1ps
module tb_lsu_rv32i;
    localparam int RD_LAT    = 1;
    localparam int DMEM_SIZE = 4096;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        cu_store;
    logic [1:0]  cu_storetype;
    logic [31:0] dmem_addr;
    logic [31:0] rs2;
    logic [31:0] dmem_out;

    lsu_rv32i #(.DMEM_RD_LAT(RD_LAT), .DMEM_SIZE_BYTES(DMEM_SIZE)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .cu_store(cu_store), .cu_storetype(cu_storetype), .dmem_addr(dmem_addr),
        .rs2(rs2), .dmem_out(dmem_out)
    );

    always #5 clock = ~clock;

    // Behavioural data memory: byte array, typed writes, pipelined word read.
    logic [7:0]  mem [0:4095];
    logic [31:0] rd_pipe [0:2];
    logic        mem_clear;
    int          wr_n;
    always @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
        end else if (cu_store) begin
            wr_n = (cu_storetype == 2'b00) ? 4 : ((cu_storetype == 2'b01) ? 2 : 1);
            for (int i = 0; i < wr_n; i++) mem[12'(dmem_addr[11:0] + 12'(i))] <= 8'(rs2 >> (8 * i));
        end
        rd_pipe[0] <= {mem[{dmem_addr[11:2], 2'b11}], mem[{dmem_addr[11:2], 2'b10}],
                       mem[{dmem_addr[11:2], 2'b01}], mem[{dmem_addr[11:2], 2'b00}]};
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
    end
    assign dmem_out = rd_pipe[RD_LAT - 1];

    int nchk = 0;
    int nfail = 0;
    logic [7:0] ref_mem [0:4095];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: outcome of one request from the architectural rules.
    task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic e_err, output logic [31:0] e_rdata,
                             output int e_lat, output int e_st);
        int n;
        bit illegal, oor, mis;
        longint v;
        n = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
        oor = (longint'(addr) + longint'(n) - 1) >= longint'(DMEM_SIZE);
        mis = (int'(addr[1:0]) % n) != 0;
        e_err = illegal || oor || (mis && !SPLIT);
        e_rdata = 32'd0; e_lat = 1; e_st = 0;
        if (!e_err) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * i));
                e_st  = mis ? n : 1;
                e_lat = mis ? n + 1 : 2;
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[int'(addr) + i]) << (8 * i));
                if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
                e_rdata = 32'(v);
                e_lat = mis ? n * (1 + RD_LAT) + 1 : 2 + RD_LAT;
            end
        end
    endtask

    // Issue one request from a negedge and observe it until its response.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic g_err, output logic [31:0] g_rdata, output int g_lat, output int g_st,
                           output logic c1_store, output logic [1:0] c1_type, output logic [31:0] c1_addr,
                           output logic [31:0] c1_rs2, output logic ready_ok);
        int w;
        bit done;
        w = 0;
        while (!req_ready && w < 20) begin @(negedge clock); w++; end
        if (!req_ready) begin
            nchk++; nfail++;
            $display("FAIL ready_timeout: req_ready stayed 0 for %0d cycles", w);
        end
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        g_err = 1'bx; g_rdata = 32'hx; g_lat = -1; g_st = 0; ready_ok = 1'b1; done = 1'b0;
        c1_store = 1'b0; c1_type = 2'b00; c1_addr = 32'd0; c1_rs2 = 32'd0;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clock);
            if (k == 1) begin
                req_valid = 1'b0;
                c1_store = cu_store; c1_type = cu_storetype; c1_addr = dmem_addr; c1_rs2 = rs2;
            end
            if (cu_store) g_st++;
            if (req_ready) ready_ok = 1'b0;
            if (resp_valid) begin
                done = 1'b1; g_lat = k; g_err = resp_err; g_rdata = resp_rdata;
            end
        end
        if (!done) begin
            nchk++; nfail++;
            $display("FAIL resp_timeout: no resp_valid within 60 cycles for addr %h", addr);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          st;
        logic [1:0]  stype;
    } vec_t;

    function automatic vec_t mk(input string name, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                                input int lat, input int st, input logic [1:0] stype);
        vec_t v;
        v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.err = err; v.rdata = rdata; v.lat = lat; v.st = st; v.stype = stype;
        return v;
    endfunction

    vec_t vecs [18];

    initial begin
        logic        g_err, e_err, c1s, rok;
        logic [31:0] g_rd, e_rd, c1a, c1r;
        logic [1:0]  c1t;
        int          g_lat, g_st, e_lat, e_st;
        int          acc, nresp, cnt_st, cnt_rv, mism;
        bit          will_acc, saw_low;
        logic [2:0]  b2b_f3 [3];
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_exp [3];
        logic [31:0] ra;

        vecs[0]  = mk("sw_4",     1'b1, 3'b010, 32'h004, 32'hAABBCCDD, 1'b0, 32'h0, 2, 1, 2'b00);
        vecs[1]  = mk("lw_4",     1'b0, 3'b010, 32'h004, 32'h0, 1'b0, 32'hAABBCCDD, 2 + RD_LAT, 0, 2'b00);
        vecs[2]  = mk("sb_3",     1'b1, 3'b000, 32'h003, 32'h000000AB, 1'b0, 32'h0, 2, 1, 2'b10);
        vecs[3]  = mk("lb_3",     1'b0, 3'b000, 32'h003, 32'h0, 1'b0, 32'hFFFFFFAB, 2 + RD_LAT, 0, 2'b00);
        vecs[4]  = mk("lbu_3",    1'b0, 3'b100, 32'h003, 32'h0, 1'b0, 32'h000000AB, 2 + RD_LAT, 0, 2'b00);
        vecs[5]  = mk("sh_6",     1'b1, 3'b001, 32'h006, 32'h00008234, 1'b0, 32'h0, 2, 1, 2'b01);
        vecs[6]  = mk("lh_6",     1'b0, 3'b001, 32'h006, 32'h0, 1'b0, 32'hFFFF8234, 2 + RD_LAT, 0, 2'b00);
        vecs[7]  = mk("lhu_6",    1'b0, 3'b101, 32'h006, 32'h0, 1'b0, 32'h00008234, 2 + RD_LAT, 0, 2'b00);
        vecs[8]  = mk("sw_8",     1'b1, 3'b010, 32'h008, 32'h11223344, 1'b0, 32'h0, 2, 1, 2'b00);
        vecs[9]  = mk("lw_6_mis", 1'b0, 3'b010, 32'h006, 32'h0, !SPLIT, SPLIT ? 32'h33448234 : 32'h0,
                      SPLIT ? 4 * (1 + RD_LAT) + 1 : 1, 0, 2'b00);
        vecs[10] = mk("sw_ffc",   1'b1, 3'b010, 32'hFFC, 32'h55667788, 1'b0, 32'h0, 2, 1, 2'b00);
        vecs[11] = mk("sw_ffe",   1'b1, 3'b010, 32'hFFE, 32'h12345678, 1'b1, 32'h0, 1, 0, 2'b00);
        vecs[12] = mk("f3_011",   1'b0, 3'b011, 32'h000, 32'h0, 1'b1, 32'h0, 1, 0, 2'b00);
        vecs[13] = mk("st_f3_100",1'b1, 3'b100, 32'h000, 32'hFFFFFFFF, 1'b1, 32'h0, 1, 0, 2'b00);
        vecs[14] = mk("lb_fff",   1'b0, 3'b000, 32'hFFF, 32'h0, 1'b0, 32'h00000055, 2 + RD_LAT, 0, 2'b00);
        vecs[15] = mk("lh_fff",   1'b0, 3'b001, 32'hFFF, 32'h0, 1'b1, 32'h0, 1, 0, 2'b00);
        vecs[16] = mk("sh_11_mis",1'b1, 3'b001, 32'h011, 32'h0000BEEF, !SPLIT, 32'h0, SPLIT ? 3 : 1,
                      SPLIT ? 2 : 0, 2'b10);
        vecs[17] = mk("lhu_11_mis",1'b0, 3'b101, 32'h011, 32'h0, !SPLIT, SPLIT ? 32'h0000BEEF : 32'h0,
                      SPLIT ? 2 * (1 + RD_LAT) + 1 : 1, 0, 2'b00);

        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        reset = 1'b1; mem_clear = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clock);
        check32("rst_cu_store", {31'd0, cu_store}, 32'd0);
        check32("rst_storetype", {30'd0, cu_storetype}, 32'd0);
        check32("rst_dmem_addr", dmem_addr, 32'd0);
        check32("rst_rs2", rs2, 32'd0);
        check32("rst_resp", {resp_rdata[30:0] | {30'd0, resp_err}, resp_valid}, 32'd0);
        check32("rst_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b0; mem_clear = 1'b0;
        @(negedge clock);
        check32("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Directed table
        for (int i = 0; i < 18; i++) begin
            run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                    g_err, g_rd, g_lat, g_st, c1s, c1t, c1a, c1r, rok);
            model_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, e_err, e_rd, e_lat, e_st);
            check32({vecs[i].name, "_err"}, {31'd0, g_err}, {31'd0, vecs[i].err});
            check32({vecs[i].name, "_rdata"}, g_rd, vecs[i].rdata);
            check32({vecs[i].name, "_latency"}, 32'(g_lat), 32'(vecs[i].lat));
            check32({vecs[i].name, "_store_pulses"}, 32'(g_st), 32'(vecs[i].st));
            check32({vecs[i].name, "_ready_low"}, {31'd0, rok}, 32'd1);
            if (vecs[i].st > 0) begin
                check32({vecs[i].name, "_c1_store"}, {31'd0, c1s}, 32'd1);
                check32({vecs[i].name, "_c1_type"}, {30'd0, c1t}, {30'd0, vecs[i].stype});
                check32({vecs[i].name, "_c1_addr"}, c1a, vecs[i].addr);
                check32({vecs[i].name, "_c1_rs2"}, c1r, vecs[i].wdata);
            end
        end

        // Back-to-back: req_valid held high across three loads
        b2b_f3[0] = 3'b010; b2b_addr[0] = 32'h008; b2b_exp[0] = 32'h11223344;
        b2b_f3[1] = 3'b100; b2b_addr[1] = 32'h003; b2b_exp[1] = 32'h000000AB;
        b2b_f3[2] = 3'b001; b2b_addr[2] = 32'h006; b2b_exp[2] = 32'hFFFF8234;
        acc = 0; nresp = 0; will_acc = 1'b0; saw_low = 1'b0;
        req_we = 1'b0; req_wdata = 32'd0; req_funct3 = b2b_f3[0]; req_addr = b2b_addr[0]; req_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (req_valid) begin
                if (req_ready) will_acc = 1'b1;
                else begin will_acc = 1'b0; if (acc > 0) saw_low = 1'b1; end
            end else begin
                will_acc = 1'b0;
            end
            @(negedge clock);
            if (resp_valid) begin
                if (nresp < 3) check32($sformatf("b2b_rdata_%0d", nresp), resp_rdata, b2b_exp[nresp]);
                nresp++;
            end
            if (will_acc) begin
                acc++;
                if (acc < 3) begin req_funct3 = b2b_f3[acc]; req_addr = b2b_addr[acc]; end
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check32("b2b_accepts", 32'(acc), 32'd3);
        check32("b2b_resp_count", 32'(nresp), 32'd3);
        check32("b2b_ready_low_between", {31'd0, saw_low}, 32'd1);

        // Randomized requests against the reference model
        for (int t = 0; t < 150; t++) begin
            logic        r_we;
            logic [2:0]  r_f3;
            logic [31:0] r_addr;
            int          sel;
            r_we = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            r_f3 = (sel < 2) ? 3'b000 : (sel == 2) ? 3'b001 : (sel < 5) ? 3'b010 : (sel == 5) ? 3'b100 :
                   (sel == 6) ? 3'b101 : (sel == 7) ? 3'b011 : (sel == 8) ? 3'b110 : 3'b111;
            sel = $urandom_range(0, 9);
            if (sel < 7) r_addr = 32'($urandom_range(0, 4095));
            else if (sel < 9) r_addr = 32'(4088 + $urandom_range(0, 10));
            else r_addr = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            run_req(r_we, r_f3, r_addr, $urandom, g_err, g_rd, g_lat, g_st, c1s, c1t, c1a, c1r, rok);
            model_req(r_we, r_f3, r_addr, req_wdata, e_err, e_rd, e_lat, e_st);
            check32($sformatf("rnd%0d_err", t), {31'd0, g_err}, {31'd0, e_err});
            check32($sformatf("rnd%0d_rdata", t), g_rd, e_rd);
            check32($sformatf("rnd%0d_latency", t), 32'(g_lat), 32'(e_lat));
            check32($sformatf("rnd%0d_store_pulses", t), 32'(g_st), 32'(e_st));
        end

        // Reset in cycle 1 of a store aborts it
        ra = SPLIT ? 32'h021 : 32'h020;
        while (!req_ready) @(negedge clock);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = ra; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        check32("mid_rst_c1_store", {31'd0, cu_store}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        if (SPLIT) ref_mem[int'(ra)] = 8'h0D;
        else for (int i = 0; i < 4; i++) ref_mem[int'(ra) + i] = 8'(32'hCAFEF00D >> (8 * i));
        cnt_st = 0; cnt_rv = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (k == 0) check32("mid_rst_ready", {31'd0, req_ready}, 32'd1);
            if (cu_store) cnt_st++;
            if (resp_valid) cnt_rv++;
        end
        check32("mid_rst_store_pulses", 32'(cnt_st), 32'd0);
        check32("mid_rst_resp_pulses", 32'(cnt_rv), 32'd0);

        // Memory image written through the DUT matches the model
        mism = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) mism++;
        check32("mem_image_mismatches", 32'(mism), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
